// File: rtl/ula_pkg.sv
// ----------------------------------------------------------------------------
// ula_pkg
// Shared definitions for the execution-stage ALU and the ALU controller:
//   - 6-bit operation codes (SOMA..NEGAR, PASS)
//   - FSM state encoding of the sequential ALU
//   - helper telling whether an op runs on the iterative unit
// ----------------------------------------------------------------------------
package ula_pkg;

  // Operation codes
  localparam logic [5:0] OP_SOMA  = 6'd0;
  localparam logic [5:0] OP_SUBT  = 6'd1;
  localparam logic [5:0] OP_MULT  = 6'd2;
  localparam logic [5:0] OP_DIVI  = 6'd3;
  localparam logic [5:0] OP_OU    = 6'd4;
  localparam logic [5:0] OP_NOU   = 6'd5;
  localparam logic [5:0] OP_E     = 6'd6;
  localparam logic [5:0] OP_NE    = 6'd7;
  localparam logic [5:0] OP_OUEX  = 6'd8;
  localparam logic [5:0] OP_NOUX  = 6'd9;
  localparam logic [5:0] OP_MENOR = 6'd10;
  localparam logic [5:0] OP_MAIOR = 6'd11;
  localparam logic [5:0] OP_IGUAL = 6'd12;
  localparam logic [5:0] OP_SHLE  = 6'd13;
  localparam logic [5:0] OP_SHRI  = 6'd14;
  localparam logic [5:0] OP_DIFER = 6'd15;
  localparam logic [5:0] OP_MOVER = 6'd16;
  localparam logic [5:0] OP_NEGAR = 6'd17;
  localparam logic [5:0] OP_PASS  = 6'd31;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIM  = 2'd3;

  // True for ops that need the multi-cycle unit
  function automatic logic is_iterative(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_DIVI);
  endfunction

endpackage

// File: rtl/ula_iterativa.sv
// ----------------------------------------------------------------------------
// ula_iterativa
// Iterative unsigned multiplier (shift-add) and restoring divider sharing one
// counter and one set of working registers. Runs exactly WIDTH iterations.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   start         : load operands and begin (a, b, is_div sampled here)
//   is_div        : 1 = quotient a/b, 0 = low WIDTH bits of a*b
//   a, b          : operands
//   result        : value produced by the iteration completing this cycle
//   done          : high during the last iteration; result valid at that edge
// ----------------------------------------------------------------------------
module ula_iterativa #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  // acc: product accumulator (MULT) or partial remainder (DIVI)
  // x  : shifting multiplicand (MULT) or dividend/quotient register (DIVI)
  // y  : shifting multiplier (MULT) or divisor (DIVI)
  logic             run_q, run_d;
  logic             div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;

  logic [WIDTH-1:0] acc_n, x_n, y_n;
  logic [WIDTH:0]   rem_shift, diff;

  always_comb begin
    rem_shift = {acc_q, x_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, y_q};
    acc_n     = acc_q;
    x_n       = x_q;
    y_n       = y_q;
    if (div_q) begin
      // Restoring step: a negative trial difference keeps the shifted remainder
      if (diff[WIDTH]) begin
        acc_n = rem_shift[WIDTH-1:0];
        x_n   = {x_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_n = diff[WIDTH-1:0];
        x_n   = {x_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_n = y_q[0] ? (acc_q + x_q) : acc_q;
      x_n   = x_q << 1;
      y_n   = y_q >> 1;
    end
  end

  assign done   = run_q && (cnt_q == CW'(WIDTH - 1));
  assign result = div_q ? x_n : acc_n;

  always_comb begin
    run_d = run_q;
    div_d = div_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    x_d   = x_q;
    y_d   = y_q;
    if (start) begin
      run_d = 1'b1;
      div_d = is_div;
      cnt_d = '0;
      acc_d = '0;
      x_d   = a;
      y_d   = b;
    end else if (run_q) begin
      acc_d = acc_n;
      x_d   = x_n;
      y_d   = y_n;
      cnt_d = cnt_q + CW'(1);
      if (done) run_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      run_q <= 1'b0;
      div_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      run_q <= run_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

endmodule

// File: rtl/ula_sequencial.sv
// ----------------------------------------------------------------------------
// ula_sequencial
// Execution-stage ALU with start/busy/done handshake. Single-cycle ops finish
// at the accepted start edge; MULT/DIVI run WIDTH iterations in ula_iterativa.
// Handshake: start is accepted only on an edge where the FSM is IDLE; result
// and flags then stay stable until the next completion; done pulses for the
// one cycle the FSM spends in FIM; busy is high while MUL/DIV iterate.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   start, op     : launch request and 6-bit op code
//   a, b          : operands
//   result        : registered result
//   busy, done    : handshake status
//   zero, neg     : result flags, loaded together with result
//   div_zero      : last completed DIVI had b == 0
// ----------------------------------------------------------------------------
module ula_sequencial
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             neg,
  output logic             div_zero
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] alu_out;
  logic             load;
  logic             it_start, it_div, it_done;
  logic [WIDTH-1:0] it_result;
  logic             shift_big;

  ula_iterativa #(.WIDTH(WIDTH)) u_iter (
    .clock  (clock),
    .reset  (reset),
    .start  (it_start),
    .is_div (it_div),
    .a      (a),
    .b      (b),
    .result (it_result),
    .done   (it_done)
  );

  // Shift amounts of WIDTH or more flush the operand to zero
  assign shift_big = (b >= WIDTH'(WIDTH));

  always_comb begin
    alu_out = a;
    case (op)
      OP_SOMA:  alu_out = a + b;
      OP_SUBT:  alu_out = a - b;
      OP_OU:    alu_out = a | b;
      OP_NOU:   alu_out = ~(a | b);
      OP_E:     alu_out = a & b;
      OP_NE:    alu_out = ~(a & b);
      OP_OUEX:  alu_out = a ^ b;
      OP_NOUX:  alu_out = ~(a ^ b);
      OP_MENOR: alu_out = WIDTH'($signed(a) < $signed(b));
      OP_MAIOR: alu_out = WIDTH'($signed(a) > $signed(b));
      OP_IGUAL: alu_out = WIDTH'(a == b);
      OP_DIFER: alu_out = WIDTH'(a != b);
      OP_SHLE:  alu_out = shift_big ? '0 : (a << b);
      OP_SHRI:  alu_out = shift_big ? '0 : (a >> b);
      OP_MOVER: alu_out = b;
      OP_NEGAR: alu_out = '0 - a;
      default:  alu_out = a;  // PASS and unused codes 18..30
    endcase
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    load       = 1'b0;
    it_start   = 1'b0;
    it_div     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MULT) begin
            it_start = 1'b1;
            busy_d   = 1'b1;
            state_d  = ST_MUL;
          end else if (op == OP_DIVI && b != '0) begin
            it_start = 1'b1;
            it_div   = 1'b1;
            busy_d   = 1'b1;
            state_d  = ST_DIV;
          end else if (op == OP_DIVI) begin
            result_d   = '1;
            div_zero_d = 1'b1;
            load       = 1'b1;
            done_d     = 1'b1;
            state_d    = ST_FIM;
          end else begin
            result_d = alu_out;
            load     = 1'b1;
            done_d   = 1'b1;
            state_d  = ST_FIM;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (it_done) begin
          result_d = it_result;
          load     = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_FIM;
          if (state_q == ST_DIV) div_zero_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;  // FIM: start is ignored here
    endcase
    // Flags follow result only when a new result is loaded
    zero_d = load ? (result_d == '0)       : zero_q;
    neg_d  = load ? result_d[WIDTH-1]      : neg_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign result   = result_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign zero     = zero_q;
  assign neg      = neg_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_ula_sequencial.sv
// ----------------------------------------------------------------------------
// tb_ula_sequencial
// Directed test of ula_sequencial (WIDTH=32) with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_ula_sequencial;
  import ula_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   op    = '0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] result;
  logic         busy, done, zero, neg, div_zero;

  int vectors = 0;
  int errors  = 0;

  ula_sequencial #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .zero     (zero),
    .neg      (neg),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one op from IDLE, scramble inputs after acceptance, wait for done.
  // lat = edges from the start edge to done high; bcnt = cycles with busy high.
  task automatic run_op(input logic [5:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int lat, output int bcnt);
    tick();  // leaves any FIM cycle so the FSM is IDLE
    op = o; a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0; a = ~av; b = ~bv; op = OP_SOMA;
    lat = 1; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
  endtask

  typedef struct {
    logic [5:0]   o;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [W-1:0] exp;
    string        tag;
  } vec_t;

  vec_t vt[19];

  initial begin
    int lat, bcnt, npulse;

    vt[0]  = '{OP_MENOR, 32'hFFFFFFFD, 32'd2,        32'd1,        "menor_neg"};
    vt[1]  = '{OP_SHRI,  32'h80000000, 32'd31,       32'd1,        "shri_31"};
    vt[2]  = '{OP_SHLE,  32'h00000001, 32'd40,       32'd0,        "shle_40"};
    vt[3]  = '{OP_SUBT,  32'd10,       32'd3,        32'd7,        "subt"};
    vt[4]  = '{OP_SUBT,  32'd3,        32'd10,       32'hFFFFFFF9, "subt_wrap"};
    vt[5]  = '{OP_OU,    32'h5,        32'hA,        32'hF,        "ou"};
    vt[6]  = '{OP_NOU,   32'h0F0F0000, 32'h0000F0F0, 32'hF0F00F0F, "nou"};
    vt[7]  = '{OP_E,     32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, "e"};
    vt[8]  = '{OP_NE,    32'hFF00FF00, 32'h0FF00FF0, 32'hF0FFF0FF, "ne"};
    vt[9]  = '{OP_OUEX,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, "ouex"};
    vt[10] = '{OP_NOUX,  32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0FF0F0, "noux"};
    vt[11] = '{OP_MAIOR, 32'd2,        32'hFFFFFFFD, 32'd1,        "maior_t"};
    vt[12] = '{OP_MAIOR, 32'hFFFFFFFD, 32'd2,        32'd0,        "maior_f"};
    vt[13] = '{OP_IGUAL, 32'd5,        32'd5,        32'd1,        "igual"};
    vt[14] = '{OP_DIFER, 32'd5,        32'd5,        32'd0,        "difer"};
    vt[15] = '{OP_SHLE,  32'd1,        32'd31,       32'h80000000, "shle_31"};
    vt[16] = '{OP_MOVER, 32'd1,        32'hDEADBEEF, 32'hDEADBEEF, "mover"};
    vt[17] = '{OP_NEGAR, 32'd5,        32'd0,        32'hFFFFFFFB, "negar"};
    vt[18] = '{6'd20,    32'hCAFEF00D, 32'd9,        32'hCAFEF00D, "op20_pass"};

    // Reset state
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_result", result, '0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_zero", zero, 0);
    check("rst_divz", div_zero, 0);

    // SOMA wraps to zero
    run_op(OP_SOMA, 32'hFFFFFFFF, 32'd1, lat, bcnt);
    check("soma_lat", lat, 1);
    check("soma_res", result, '0);
    check("soma_zero", zero, 1);
    check("soma_busy", bcnt, 0);
    tick();
    check("soma_done_pulse", done, 0);

    // MULT
    run_op(OP_MULT, 32'd1234, 32'd5678, lat, bcnt);
    check("mult_lat", lat, 33);
    check("mult_res", result, 32'd7006652);
    check("mult_busy_cycles", bcnt, 32);
    check("mult_zero", zero, 0);

    // Reset in the middle of a MULT
    tick();
    op = OP_MULT; a = 32'd77; b = 32'd99; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("midrst_result", result, '0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    npulse = 0;
    repeat (40) begin
      tick();
      if (done) npulse++;
    end
    check("midrst_no_done", npulse, 0);

    // DIVI
    run_op(OP_DIVI, 32'd100, 32'd7, lat, bcnt);
    check("divi_lat", lat, 33);
    check("divi_res", result, 32'd14);
    check("divi_divz", div_zero, 0);
    run_op(OP_DIVI, 32'hFFFFFFFF, 32'd16, lat, bcnt);
    check("divi_big", result, 32'h0FFFFFFF);
    run_op(OP_DIVI, 32'd100, 32'd0, lat, bcnt);
    check("divz_lat", lat, 1);
    check("divz_res", result, 32'hFFFFFFFF);
    check("divz_flag", div_zero, 1);
    check("divz_neg", neg, 1);
    run_op(OP_SOMA, 32'd2, 32'd3, lat, bcnt);
    check("divz_sticky_res", result, 32'd5);
    check("divz_sticky", div_zero, 1);
    run_op(OP_DIVI, 32'd9, 32'd3, lat, bcnt);
    check("divz_clear_res", result, 32'd3);
    check("divz_clear", div_zero, 0);

    // Single-cycle op table
    foreach (vt[i]) begin
      run_op(vt[i].o, vt[i].av, vt[i].bv, lat, bcnt);
      check({vt[i].tag, "_lat"}, lat, 1);
      check({vt[i].tag, "_res"}, result, vt[i].exp);
      check({vt[i].tag, "_zero"}, zero, (vt[i].exp == '0));
      check({vt[i].tag, "_neg"}, neg, vt[i].exp[W-1]);
    end

    // start during MULT and during FIM is ignored
    tick();
    op = OP_MULT; a = 32'd3; b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    repeat (4) begin tick(); lat++; end
    op = OP_SOMA; a = 32'd1; b = 32'd1; start = 1'b1;
    tick(); lat++;
    start = 1'b0;
    while (!done && lat < 100) begin tick(); lat++; end
    check("ign_lat", lat, 33);
    check("ign_res", result, 32'd12);
    op = OP_SOMA; a = 32'd7; b = 32'd7; start = 1'b1;  // FSM is in FIM here
    tick();
    start = 1'b0;
    check("ign_fim_done", done, 0);
    npulse = 0;
    repeat (40) begin
      tick();
      if (done) npulse++;
    end
    check("ign_no_done", npulse, 0);
    check("ign_res_held", result, 32'd12);
    check("ign_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
